// File: rtl/set_key_ctrl_pkg.sv
// Shared encodings for the front-panel key controller: field-select codes
// and the INC hold-to-repeat state machine.
package set_key_ctrl_pkg;

  localparam logic [1:0] SEL_RUN  = 2'b00;
  localparam logic [1:0] SEL_SEC  = 2'b01;
  localparam logic [1:0] SEL_MIN  = 2'b10;
  localparam logic [1:0] SEL_HOUR = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } rep_state_e;

endpackage

// File: rtl/set_key_ctrl_key_debounce.sv
// One push-button input path: 2-flop synchroniser, stability counter and
// a one-cycle press strobe that rises together with the debounced level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic cr,
  input  logic key_raw,
  output logic key_level,
  output logic key_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised input disagrees with the level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!cr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_level = level_q;
  assign key_press = press_q;

endmodule

// File: rtl/set_key_ctrl.sv
// Key controller feeding the timekeeping core: MODE steps the set field,
// INC issues confirm strobes with hold-to-repeat, inactivity returns to run.
module set_key_ctrl
  import set_key_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100,
  parameter int TIMEOUT_CYCLES  = 10000
) (
  input  logic       clk,
  input  logic       cr,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [1:0] clock_set_select,
  output logic       set_confirm,
  output logic       setting
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(REP_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] R_ONE    = RW'(1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic mode_level, mode_press, inc_level, inc_press;
  logic mode_prev_q, inc_prev_q;
  logic key_edge, timeout, pulse;

  rep_state_e    state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          confirm_q, confirm_d;
  logic          setting_q, setting_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk(clk), .cr(cr), .key_raw(key_mode), .key_level(mode_level), .key_press(mode_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk(clk), .cr(cr), .key_raw(key_inc), .key_level(inc_level), .key_press(inc_press)
  );

  always_ff @(posedge clk) begin
    if (!cr) begin
      state_q     <= IDLE;
      sel_q       <= SEL_RUN;
      rcnt_q      <= '0;
      tcnt_q      <= '0;
      confirm_q   <= 1'b0;
      setting_q   <= 1'b0;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rcnt_q      <= rcnt_d;
      tcnt_q      <= tcnt_d;
      confirm_q   <= confirm_d;
      setting_q   <= setting_d;
      mode_prev_q <= mode_level;
      inc_prev_q  <= inc_level;
    end
  end

  // A MODE press aborts any repeat; the previous strobe gates the next so
  // strobes never land back to back even with a one-cycle period.
  always_comb begin
    key_edge = (mode_level != mode_prev_q) || (inc_level != inc_prev_q);
    timeout  = (sel_q != SEL_RUN) && (tcnt_q == T_LAST) && !key_edge;
    state_d  = state_q;
    sel_d    = sel_q;
    rcnt_d   = rcnt_q;
    pulse    = 1'b0;

    if (mode_press) sel_d = sel_q + 2'd1;

    unique case (state_q)
      IDLE: begin
        if (inc_press) begin
          if (mode_press) begin
            state_d = LOCK;
          end else if (sel_q != SEL_RUN) begin
            pulse   = 1'b1;
            state_d = HOLD;
            rcnt_d  = R_DELAY;
          end
        end
      end
      HOLD, REPEAT: begin
        if (!inc_level) begin
          state_d = IDLE;
        end else if (mode_press) begin
          state_d = LOCK;
        end else if ((rcnt_q <= R_ONE) && !confirm_q && (sel_q != SEL_RUN)) begin
          pulse   = 1'b1;
          state_d = REPEAT;
          rcnt_d  = R_PERIOD;
        end else if (rcnt_q > R_ONE) begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      LOCK: begin
        if (!inc_level) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      sel_d   = SEL_RUN;
      state_d = IDLE;
      pulse   = 1'b0;
    end

    if ((sel_q == SEL_RUN) || key_edge || timeout) begin
      tcnt_d = '0;
    end else if (!mode_level && !inc_level && (tcnt_q != T_LAST)) begin
      tcnt_d = tcnt_q + 1'b1;
    end else begin
      tcnt_d = tcnt_q;
    end
  end

  always_comb begin
    confirm_d = pulse;
    setting_d = (sel_d != SEL_RUN);
  end

  assign clock_set_select = sel_q;
  assign set_confirm      = confirm_q;
  assign setting          = setting_q;

endmodule
